// File: rtl/map_prg_latch_gen_pkg.sv
// Shared definitions for the PRG bank latch: bank modes, save-state register
// indices, write-filter states and CPU window decode.
package map_prg_latch_gen_pkg;

   localparam int MODE_16K_FIXED  = 0;
   localparam int MODE_32K        = 1;
   localparam int MODE_16K_MIRROR = 2;

   localparam logic [7:0] SS_ADDR_INNER = 8'd0;
   localparam logic [7:0] SS_ADDR_OUTER = 8'd1;
   localparam logic [7:0] SS_ADDR_FSM   = 8'd2;

   localparam logic [1:0] WIN_OUTER = 2'b10;
   localparam logic [1:0] WIN_INNER = 2'b11;

   typedef enum logic {
      FLT_IDLE  = 1'b0,
      FLT_ARMED = 1'b1
   } flt_state_t;

   typedef struct packed {
      logic outer_wr;
      logic inner_wr;
   } bus_dec_t;

   // Save-state access owns the bus, so it masks every CPU register write.
   function automatic bus_dec_t decode_bus(input logic [15:0] addr,
                                           input logic        rw,
                                           input logic        ss_act);
      bus_dec_t dec;
      dec.outer_wr = !rw && !ss_act && (addr[15:14] == WIN_OUTER);
      dec.inner_wr = !rw && !ss_act && (addr[15:14] == WIN_INNER);
      return dec;
   endfunction

endpackage

// File: rtl/map_wr_filter.sv
// Read-modify-write double-write filter: after an accepted write, a write on
// the very next m2 cycle is swallowed so RMW instructions update only once.
module map_wr_filter
   import map_prg_latch_gen_pkg::*;
#(
   parameter int RMW_FILTER = 1
) (
   input  logic       m2,
   input  logic       map_rst_n,
   input  logic       wr_req,
   input  logic       ss_act,
   input  logic       ss_load,
   input  logic       ss_state,
   output logic       wr_ok,
   output flt_state_t state
);

   logic armed_block;

   assign armed_block = (RMW_FILTER != 0) && (state == FLT_ARMED);
   assign wr_ok       = wr_req && !ss_act && !armed_block;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block ordering.
   always_ff @(negedge m2 or negedge map_rst_n) begin
      if (!map_rst_n) begin
         state <= FLT_IDLE;
      end else if (RMW_FILTER == 0) begin
         state <= FLT_IDLE;
      end else if (ss_load) begin
         state <= flt_state_t'(ss_state);
      end else if (ss_act) begin
         state <= FLT_IDLE;
      end else if ((state == FLT_IDLE) && wr_ok) begin
         state <= FLT_ARMED;
      end else begin
         state <= FLT_IDLE;
      end
   end

endmodule

// File: rtl/map_prg_latch_gen.sv
// Outer/inner PRG bank latch with write-once outer lock, bank modes, bus
// conflicts and RMW filter. Save-state access enabled by MAP_PRG_LATCH_SS_EN.
module map_prg_latch_gen
   import map_prg_latch_gen_pkg::*;
#(
   parameter int OUTER_W      = 3,
   parameter int INNER_W      = 4,
   parameter int MODE         = 0,
   parameter int BUS_CONFLICT = 0,
   parameter int RMW_FILTER   = 1
) (
   input  logic                          m2,
   input  logic                          map_rst_n,
   input  logic [15:0]                   cpu_addr,
   input  logic [7:0]                    cpu_dat,
   input  logic                          cpu_rw,
   input  logic [7:0]                    prg_dat,
   input  logic                          ss_act,
   input  logic                          ss_we,
   input  logic [7:0]                    ss_addr,
   input  logic [7:0]                    ss_wdat,
   output logic [7:0]                    ss_rdat,
   output logic [14+OUTER_W+INNER_W-1:0] prg_addr,
   output logic                          locked,
   output logic                          wr_ack
);

   logic [OUTER_W-1:0] outer;
   logic [INNER_W-1:0] inner;
   logic [INNER_W-1:0] bank;
   logic [7:0]         d_eff;
   bus_dec_t           dec;
   logic               outer_req;
   logic               inner_req;
   logic               wr_ok;
   flt_state_t         flt_state;
   logic               ss_ld_inner;
   logic               ss_ld_outer;
   logic               ss_ld_fsm;

   // Bus conflict: the ROM drives the data bus too, so the open-drain AND wins.
   assign d_eff = (BUS_CONFLICT != 0) ? (cpu_dat & prg_dat) : cpu_dat;

   assign dec       = decode_bus(cpu_addr, cpu_rw, ss_act);
   assign outer_req = dec.outer_wr && !locked;
   assign inner_req = dec.inner_wr;

`ifdef MAP_PRG_LATCH_SS_EN
   logic ss_wr;

   assign ss_wr       = ss_act && ss_we;
   assign ss_ld_inner = ss_wr && (ss_addr == SS_ADDR_INNER);
   assign ss_ld_outer = ss_wr && (ss_addr == SS_ADDR_OUTER);
   assign ss_ld_fsm   = ss_wr && (ss_addr == SS_ADDR_FSM);

   // NOTE: every combinational output gets a default first so no path
   // through the block leaves it unassigned and infers a latch.
   always_comb begin
      ss_rdat = 8'hff;
      case (ss_addr)
         SS_ADDR_INNER: ss_rdat = 8'(inner);
         SS_ADDR_OUTER: ss_rdat = 8'({locked, outer});
         SS_ADDR_FSM:   ss_rdat = {7'd0, flt_state};
         default:       ss_rdat = 8'hff;
      endcase
   end

   logic unused_ss;
   assign unused_ss = ^{ss_wdat, d_eff};
`else
   assign ss_ld_inner = 1'b0;
   assign ss_ld_outer = 1'b0;
   assign ss_ld_fsm   = 1'b0;
   assign ss_rdat     = 8'hff;

   logic unused_ss;
   assign unused_ss = ^{ss_we, ss_addr, ss_wdat, flt_state, d_eff};
`endif

   map_wr_filter #(
      .RMW_FILTER (RMW_FILTER)
   ) u_filter (
      .m2        (m2),
      .map_rst_n (map_rst_n),
      .wr_req    (outer_req || inner_req),
      .ss_act    (ss_act),
      .ss_load   (ss_ld_fsm),
      .ss_state  (ss_wdat[0]),
      .wr_ok     (wr_ok),
      .state     (flt_state)
   );

   always_ff @(negedge m2 or negedge map_rst_n) begin
      if (!map_rst_n) begin
         outer  <= '0;
         inner  <= '0;
         locked <= 1'b0;
         wr_ack <= 1'b0;
      end else begin
         wr_ack <= wr_ok;
         if (ss_ld_outer) begin
            outer  <= ss_wdat[OUTER_W-1:0];
            locked <= ss_wdat[OUTER_W];
         end else if (wr_ok && outer_req) begin
            outer  <= d_eff[OUTER_W-1:0];
            locked <= d_eff[OUTER_W];
         end
         if (ss_ld_inner) begin
            inner <= ss_wdat[INNER_W-1:0];
         end else if (wr_ok && inner_req) begin
            inner <= d_eff[INNER_W-1:0];
         end
      end
   end

   // 32K mode pairs inner banks, so A14 replaces the inner LSB.
   always_comb begin
      bank = inner;
      if (MODE == MODE_16K_FIXED) begin
         bank = cpu_addr[14] ? '1 : inner;
      end else if (MODE == MODE_32K) begin
         bank = (inner & ~INNER_W'(1)) | INNER_W'(cpu_addr[14]);
      end
   end

   assign prg_addr = {outer, bank, cpu_addr[13:0]};

endmodule

// File: tb/tb_map_prg_latch_gen.sv
// Directed bench for map_prg_latch_gen: default instance plus a MODE1,
// bus-conflict, unfiltered instance sharing the same CPU bus.
module tb_map_prg_latch_gen;

   logic        m2 = 1'b0;
   logic        map_rst_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dat;
   logic        cpu_rw;
   logic [7:0]  prg_dat;
   logic        ss_act;
   logic        ss_we;
   logic [7:0]  ss_addr;
   logic [7:0]  ss_wdat;
   logic [7:0]  ss_rdat, ss_rdat_b;
   logic [20:0] prg_addr, prg_addr_b;
   logic        locked, locked_b;
   logic        wr_ack, wr_ack_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 m2 = ~m2;

   map_prg_latch_gen dut (
      .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
      .cpu_rw(cpu_rw), .prg_dat(prg_dat), .ss_act(ss_act), .ss_we(ss_we),
      .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
      .prg_addr(prg_addr), .locked(locked), .wr_ack(wr_ack)
   );

   map_prg_latch_gen #(.MODE(1), .BUS_CONFLICT(1), .RMW_FILTER(0)) dut_b (
      .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
      .cpu_rw(cpu_rw), .prg_dat(prg_dat), .ss_act(ss_act), .ss_we(ss_we),
      .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat_b),
      .prg_addr(prg_addr_b), .locked(locked_b), .wr_ack(wr_ack_b)
   );

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  dat;
      logic        rw;
      logic [6:0]  exp_hi;
      logic        exp_ack;
      logic        exp_lock;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic [15:0] addr, input logic [7:0] dat, input logic rw, input logic ss);
      @(posedge m2);
      #1;
      cpu_addr = addr;
      cpu_dat  = dat;
      cpu_rw   = rw;
      ss_act   = ss;
      #1;
   endtask

   task automatic after_edge();
      @(negedge m2);
      #1;
      cpu_rw = 1'b1;
      ss_act = 1'b0;
      ss_we  = 1'b0;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [7:0] dat);
      cyc(addr, dat, 1'b0, 1'b0);
      after_edge();
   endtask

   task automatic pulse_reset();
      @(posedge m2);
      #1 map_rst_n = 1'b0;
      #2 map_rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{16'h8000, 8'h00, 1'b1, 7'h00, 1'b0, 1'b0};
      vecs[1]  = '{16'hC000, 8'h00, 1'b1, 7'h0F, 1'b0, 1'b0};
      vecs[2]  = '{16'hC000, 8'h09, 1'b0, 7'h0F, 1'b1, 1'b0};
      vecs[3]  = '{16'h8000, 8'h00, 1'b1, 7'h09, 1'b0, 1'b0};
      vecs[4]  = '{16'h8000, 8'h0B, 1'b0, 7'h09, 1'b1, 1'b1};
      vecs[5]  = '{16'h8000, 8'h00, 1'b1, 7'h39, 1'b0, 1'b1};
      vecs[6]  = '{16'hC000, 8'h00, 1'b1, 7'h3F, 1'b0, 1'b1};
      vecs[7]  = '{16'h8000, 8'h02, 1'b0, 7'h39, 1'b0, 1'b1};
      vecs[8]  = '{16'h8000, 8'h00, 1'b1, 7'h39, 1'b0, 1'b1};
      vecs[9]  = '{16'hC000, 8'h05, 1'b0, 7'h3F, 1'b1, 1'b1};
      vecs[10] = '{16'h8000, 8'h00, 1'b1, 7'h35, 1'b0, 1'b1};
      vecs[11] = '{16'h4000, 8'h07, 1'b0, 7'h3F, 1'b0, 1'b1};
      vecs[12] = '{16'h8123, 8'h00, 1'b1, 7'h35, 1'b0, 1'b1};

      map_rst_n = 1'b0;
      cpu_addr  = 16'h8000;
      cpu_dat   = 8'h00;
      cpu_rw    = 1'b1;
      prg_dat   = 8'hff;
      ss_act    = 1'b0;
      ss_we     = 1'b0;
      ss_addr   = 8'h00;
      ss_wdat   = 8'h00;
      #1;
      check("reset prg_addr", prg_addr, 21'h0);
      check("reset locked", locked, 1'b0);
      check("reset wr_ack", wr_ack, 1'b0);
`ifdef MAP_PRG_LATCH_SS_EN
      check("reset ss_rdat inner", ss_rdat, 8'h00);
`else
      check("reset ss_rdat", ss_rdat, 8'hff);
`endif
      #11 map_rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         cyc(vecs[i].addr, vecs[i].dat, vecs[i].rw, 1'b0);
         check($sformatf("vec%0d prg_addr", i), prg_addr, {vecs[i].exp_hi, vecs[i].addr[13:0]});
         after_edge();
         check($sformatf("vec%0d wr_ack", i), wr_ack, vecs[i].exp_ack);
         check($sformatf("vec%0d locked", i), locked, vecs[i].exp_lock);
      end

      // Back-to-back writes: the second is an RMW echo and must be dropped.
      wr(16'hC000, 8'h01);
      check("rmw_a first ack", wr_ack, 1'b1);
      wr(16'hC000, 8'h02);
      check("rmw_a second ack", wr_ack, 1'b0);
      cyc(16'h8000, 8'h00, 1'b1, 1'b0);
      check("rmw_a bank", prg_addr[20:14], 7'h31);

      wr(16'hC000, 8'h04);
      check("rmw_b first ack", wr_ack, 1'b1);
      wr(16'hC000, 8'h06);
      check("rmw_b second ack", wr_ack, 1'b0);
      wr(16'hC000, 8'h07);
      check("rmw_b third ack", wr_ack, 1'b1);
      cyc(16'h8000, 8'h00, 1'b1, 1'b0);
      check("rmw_b bank", prg_addr[20:14], 7'h37);

      // Reset while ARMED, then a write on the very next edge must land.
      wr(16'hC000, 8'h02);
      check("pre-reset ack", wr_ack, 1'b1);
      @(posedge m2);
      #1;
      map_rst_n = 1'b0;
      cpu_addr  = 16'h8000;
      cpu_rw    = 1'b1;
      #1;
      check("mid reset prg_addr", prg_addr, 21'h0);
      check("mid reset locked", locked, 1'b0);
      check("mid reset wr_ack", wr_ack, 1'b0);
      cpu_addr  = 16'hC000;
      cpu_dat   = 8'h03;
      cpu_rw    = 1'b0;
      #1 map_rst_n = 1'b1;
      after_edge();
      check("post-reset write ack", wr_ack, 1'b1);
      cyc(16'h8000, 8'h00, 1'b1, 1'b0);
      check("post-reset bank", prg_addr[20:14], 7'h03);

      // Save-state activity blocks CPU writes.
      cyc(16'h8000, 8'h0E, 1'b0, 1'b1);
      after_edge();
      check("ss_act blocked ack", wr_ack, 1'b0);
      check("ss_act blocked lock", locked, 1'b0);
      cyc(16'h8000, 8'h00, 1'b1, 1'b0);
      check("ss_act blocked bank", prg_addr[20:14], 7'h03);

      ss_addr = 8'h00;
      #1;
`ifdef MAP_PRG_LATCH_SS_EN
      check("ss_rdat inner", ss_rdat, 8'h03);
`else
      check("ss_rdat disabled", ss_rdat, 8'hff);
`endif
      @(posedge m2);
      #1;
      ss_act  = 1'b1;
      ss_we   = 1'b1;
      ss_addr = 8'h01;
      ss_wdat = 8'h0A;
      after_edge();
      cyc(16'h8000, 8'h00, 1'b1, 1'b0);
`ifdef MAP_PRG_LATCH_SS_EN
      check("ss restore locked", locked, 1'b1);
      check("ss restore bank", prg_addr[20:14], 7'h23);
      check("ss_rdat outer", ss_rdat, 8'h0A);
      ss_addr = 8'h05;
      #1;
      check("ss_rdat unmapped", ss_rdat, 8'hff);
`else
      check("ss ignored locked", locked, 1'b0);
      check("ss ignored bank", prg_addr[20:14], 7'h03);
      check("ss_rdat still ff", ss_rdat, 8'hff);
`endif

      // Second instance: MODE1, bus conflict, no RMW filter.
      pulse_reset();
      check("b reset prg_addr", prg_addr_b[20:14], 7'h00);
      prg_dat = 8'h06;
      wr(16'hC000, 8'h0F);
      check("b conflict ack", wr_ack_b, 1'b1);
      prg_dat = 8'hff;
      cyc(16'h8000, 8'h00, 1'b1, 1'b0);
      check("b conflict bank 8000", prg_addr_b[20:14], 7'h06);
      cyc(16'hC000, 8'h00, 1'b1, 1'b0);
      check("b conflict bank C000", prg_addr_b[20:14], 7'h07);

      wr(16'hC000, 8'h0F);
      check("b nofilter first ack", wr_ack_b, 1'b1);
      wr(16'hC000, 8'h05);
      check("b nofilter second ack", wr_ack_b, 1'b1);
      cyc(16'h8000, 8'h00, 1'b1, 1'b0);
      check("b mode1 bank 8000", prg_addr_b[20:14], 7'h04);
      cyc(16'hC000, 8'h00, 1'b1, 1'b0);
      check("b mode1 bank C000", prg_addr_b[20:14], 7'h05);

      wr(16'h8000, 8'h0B);
      check("b outer lock", locked_b, 1'b1);
      cyc(16'hC000, 8'h00, 1'b1, 1'b0);
      check("b outer bank C000", prg_addr_b[20:14], 7'h35);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
